// File: rtl/ex_mem_queue.sv
// EX->MEM skid queue: small circular FIFO holding ALU results
// between execute and memory stages, with flush and occupancy FSM.
module ex_mem_queue #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_res,
  input  logic                       in_zero,
  input  logic [RD_W-1:0]            in_rd,
  input  logic                       in_wr,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_res,
  output logic                       out_zero,
  output logic [RD_W-1:0]            out_rd,
  output logic                       out_wr,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DATA_W + RD_W + 2;
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [EW-1:0]   mem_q [DEPTH];
  logic [EW-1:0]   head;
  logic            push, pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= EMPTY;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is data-only; validity lives entirely in the pointers.
  always_ff @(posedge clk) begin
    if (push && !reset)
      mem_q[wr_ptr_q] <= {in_res, in_zero, in_rd, in_wr};
  end

  always_comb begin
    push     = in_valid && in_ready && !flush;
    pop      = out_valid && out_ready && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    state_d  = state_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      state_d  = EMPTY;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + ONE;
        2'b01:   count_d = count_q - ONE;
        default: count_d = count_q;
      endcase
      unique case (state_q)
        EMPTY: begin
          if (push) state_d = PARTIAL;
        end
        PARTIAL: begin
          if (push && !pop && count_q == LAST)
            state_d = FULL;
          else if (pop && !push && count_q == ONE)
            state_d = EMPTY;
        end
        FULL: begin
          if (pop) state_d = PARTIAL;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q != FULL);
    out_valid = (state_q != EMPTY);
    head      = out_valid ? mem_q[rd_ptr_q] : '0;
    {out_res, out_zero, out_rd, out_wr} = head;
    count     = count_q;
  end

endmodule

// File: tb/tb_ex_mem_queue.sv
// Directed bench for ex_mem_queue: hand-computed vectors checked
// with immediate assertions.
module tb_ex_mem_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] in_res;
  logic        in_zero;
  logic [4:0]  in_rd;
  logic        in_wr;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_res;
  logic        out_zero;
  logic [4:0]  out_rd;
  logic        out_wr;
  logic [2:0]  count;

  int vec  = 0;
  int miss = 0;

  ex_mem_queue #(.DATA_W(32), .RD_W(5), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_res(in_res), .in_zero(in_zero),
    .in_rd(in_rd), .in_wr(in_wr),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_zero(out_zero),
    .out_rd(out_rd), .out_wr(out_wr),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [31:0] v);
    in_valid = 1'b1;
    in_res   = v;
    tick();
    in_valid = 1'b0;
  endtask

  logic [31:0] exp_q [4];
  logic [31:0] exp6 [6];

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_res = '0; in_zero = 1'b0;
    in_rd = '0; in_wr = 1'b0; flush = 1'b0; out_ready = 1'b0;
    #3;
    chk("rst_count", count, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_res", out_res, 0);
    tick();
    reset = 1'b0;

    // single push, one-cycle latency
    in_zero = 1'b1; in_rd = 5'd3; in_wr = 1'b1;
    push1(32'h5);
    in_zero = 1'b0; in_rd = '0; in_wr = 1'b0;
    chk("p1_valid", out_valid, 1);
    chk("p1_res", out_res, 32'h5);
    chk("p1_zero", out_zero, 1);
    chk("p1_rd", out_rd, 3);
    chk("p1_wr", out_wr, 1);
    chk("p1_count", count, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("p1_pop_count", count, 0);
    chk("p1_pop_valid", out_valid, 0);
    chk("p1_pop_res", out_res, 0);

    // fill to full, overflow attempt, drain
    exp_q[0] = 32'h11; exp_q[1] = 32'h22;
    exp_q[2] = 32'h33; exp_q[3] = 32'h44;
    for (int i = 0; i < 4; i++) push1(exp_q[i]);
    chk("full_count", count, 4);
    chk("full_ready", in_ready, 0);
    push1(32'h55);
    chk("ovf_count", count, 4);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_res", out_res, exp_q[i]);
      tick();
    end
    out_ready = 1'b0;
    chk("drain_valid", out_valid, 0);
    chk("drain_count", count, 0);

    // steady push+pop at count 2 with pointer wrap
    push1(32'hA0);
    push1(32'hA1);
    exp6[0] = 32'hA0; exp6[1] = 32'hA1; exp6[2] = 32'h1;
    exp6[3] = 32'h2;  exp6[4] = 32'h3;  exp6[5] = 32'h4;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_res = 32'(i + 1);
      chk("pp_head", out_res, exp6[i]);
      tick();
      chk("pp_count", count, 2);
    end
    in_valid = 1'b0;
    chk("pp_tail0", out_res, 32'h5);
    tick();
    chk("pp_tail1", out_res, 32'h6);
    tick();
    out_ready = 1'b0;
    chk("pp_empty", out_valid, 0);

    // flush beats push and pop
    push1(32'h31); push1(32'h32); push1(32'h33);
    chk("fl_pre", count, 3);
    flush = 1'b1; in_valid = 1'b1; in_res = 32'h99; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("fl_count", count, 0);
    chk("fl_valid", out_valid, 0);
    chk("fl_res", out_res, 0);
    chk("fl_ready", in_ready, 1);
    push1(32'h77);
    chk("fl_next", out_res, 32'h77);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("fl_next_pop", count, 0);

    // async reset mid-operation
    push1(32'hC1); push1(32'hC2);
    #2 reset = 1'b1;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_count", count, 0);
    chk("ar_ready", in_ready, 1);
    chk("ar_res", out_res, 0);
    in_valid = 1'b1; in_res = 32'hEE;
    tick();
    chk("ar_nopush", count, 0);
    reset = 1'b0;
    push1(32'hAB);
    chk("ar_first", out_res, 32'hAB);
    chk("ar_cnt1", count, 1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("ar_pop", count, 0);

    // full with both handshakes offered: pop only
    for (int i = 0; i < 4; i++) push1(32'hD0 + 32'(i));
    in_valid = 1'b1; in_res = 32'hDD; out_ready = 1'b1;
    chk("fp_ready0", in_ready, 0);
    tick();
    in_valid = 1'b0;
    chk("fp_count", count, 3);
    chk("fp_ready1", in_ready, 1);
    for (int i = 1; i < 4; i++) begin
      chk("fp_drain", out_res, 32'hD0 + 32'(i));
      tick();
    end
    out_ready = 1'b0;
    chk("fp_empty", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
